// File: rtl/data_gen_wrap_pkg.sv
// Shared definitions for the data_gen_wrap packet source: info-word field
// offsets, controller state encoding and the fixed packet length used when
// DGW_FIXED_LEN_EN is defined.
package data_gen_wrap_pkg;

  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned SEQ_LSB   = 16;
  localparam int unsigned SEQ_W     = 16;
  localparam int unsigned FIXED_LEN = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/data_gen_wrap_fifo.sv
// dgw_sync_fifo: synchronous FIFO with registered full/empty flags and a
// show-ahead read port.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   i_wr, i_wr_data       - push request and data
//   i_rd                  - pop request (ignored while empty)
//   o_rd_data_c           - head of queue (write data when empty)
//   o_full, o_empty       - occupancy flags
module dgw_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rd_data_c,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [CW-1:0]     r_cnt;
  logic              r_full, r_empty;
  logic              w_byp, w_push, w_pop;
  logic [CW-1:0]     w_cnt_nxt;

  // Push and pop on an empty FIFO pass the word straight through.
  assign w_byp       = i_wr && i_rd && r_empty;
  assign w_push      = i_wr && !w_byp && (!r_full || i_rd);
  assign w_pop       = i_rd && !r_empty;
  assign w_cnt_nxt   = r_cnt + CW'(w_push) - CW'(w_pop);
  assign o_rd_data_c = r_empty ? i_wr_data : r_mem[r_rptr];
  assign o_full      = r_full;
  assign o_empty     = r_empty;

  // Storage array
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  // Pointers, count and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/data_gen_wrap.sv
// data_gen_wrap: self-contained packet traffic source. A generator writes
// packet payload into a ring-buffer RAM and pushes one info word per packet
// into an info FIFO; a send controller pops info words and streams packets
// out with sop/vld/eop framing.
// Optional macro DGW_FIXED_LEN_EN: every packet is FIXED_LEN words long.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   o_sop      - first word of packet
//   o_vld      - o_data valid
//   o_data     - payload word
//   o_eop      - last word of packet
module data_gen_wrap
  import data_gen_wrap_pkg::*;
#(
  parameter int unsigned GEN_INF_W   = 32,
  parameter int unsigned FIFO_ADDR_W = 5,
  parameter int unsigned RAM_ADDR_W  = 5,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          o_sop,
  output logic          o_vld,
  output logic [DW-1:0] o_data,
  output logic          o_eop
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_W;
  localparam int unsigned OCC_W     = RAM_ADDR_W + 1;

  // Generator state
  logic                  r_gen_busy;
  logic [SEQ_W-1:0]      r_seq;
  logic [RAM_ADDR_W-1:0] r_widx, r_wptr;
  logic [OCC_W-1:0]      r_occ;
  logic [RAM_ADDR_W-1:0] w_len_m1, w_widx;
  logic [OCC_W-1:0]      w_len, w_free;
  logic                  w_start, w_wr, w_last;
  logic [DW-1:0]         w_wdata;
  logic [GEN_INF_W-1:0]  w_info;

  // Info FIFO
  logic [GEN_INF_W-1:0]  w_fifo_rdata;
  logic                  w_fifo_full, w_fifo_empty;
  logic                  w_unused_info;

  // Controller state
  ctrl_state_e           r_state, w_state_nxt;
  logic [RAM_ADDR_W-1:0] r_plen_m1, r_rcnt, r_rptr;
  logic                  w_pop, w_rd;

  // Payload RAM and output stage
  logic [DW-1:0]         r_ram [RAM_DEPTH];
  logic [DW-1:0]         r_data;
  logic                  r_vld, r_sop, r_eop;

`ifdef DGW_FIXED_LEN_EN
  assign w_len_m1 = RAM_ADDR_W'(FIXED_LEN - 1);
`else
  assign w_len_m1 = RAM_ADDR_W'(r_seq);
`endif

  // A packet starts only when its whole length fits in the RAM, so the
  // controller never waits on partially written payload.
  assign w_len   = OCC_W'(w_len_m1) + OCC_W'(1);
  assign w_free  = OCC_W'(RAM_DEPTH) - r_occ;
  assign w_start = !r_gen_busy && !w_fifo_full && (w_free >= w_len);
  assign w_wr    = w_start || r_gen_busy;
  assign w_widx  = r_gen_busy ? r_widx : '0;
  assign w_last  = w_wr && (w_widx == w_len_m1);
  assign w_wdata = DW'({r_seq, 16'(w_widx)});

  // Info word assembly
  always_comb begin
    w_info = '0;
    w_info[LEN_LSB +: RAM_ADDR_W] = w_len_m1;
    w_info[SEQ_LSB +: SEQ_W]      = r_seq;
  end

  // Generator sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gen_busy <= 1'b0;
      r_seq      <= '0;
      r_widx     <= '0;
      r_wptr     <= '0;
    end else if (w_wr) begin
      r_wptr <= r_wptr + RAM_ADDR_W'(1);
      if (w_last) begin
        r_gen_busy <= 1'b0;
        r_widx     <= '0;
        r_seq      <= r_seq + SEQ_W'(1);
      end else begin
        r_gen_busy <= 1'b1;
        r_widx     <= w_widx + RAM_ADDR_W'(1);
      end
    end
  end

  // RAM occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= '0;
    else        r_occ <= r_occ + OCC_W'(w_wr) - OCC_W'(w_rd);
  end

  dgw_sync_fifo #(
    .DATA_W (GEN_INF_W),
    .ADDR_W (FIFO_ADDR_W)
  ) u_info_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr        (w_last),
    .i_wr_data   (w_info),
    .i_rd        (w_pop),
    .o_rd_data_c (w_fifo_rdata),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Only the length field steers the controller; seq travels in the payload.
  assign w_unused_info = ^w_fifo_rdata;

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Controller next-state and strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rd        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_rd = 1'b1;
        if (r_rcnt == r_plen_m1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Controller datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plen_m1 <= '0;
      r_rcnt    <= '0;
      r_rptr    <= '0;
    end else if (w_pop) begin
      r_plen_m1 <= w_fifo_rdata[LEN_LSB +: RAM_ADDR_W];
      r_rcnt    <= '0;
    end else if (w_rd) begin
      r_rcnt <= r_rcnt + RAM_ADDR_W'(1);
      r_rptr <= r_rptr + RAM_ADDR_W'(1);
    end
  end

  // Payload RAM write port
  always_ff @(posedge clk) begin
    if (w_wr) r_ram[r_wptr] <= w_wdata;
  end

  // Synchronous read and framing, aligned to the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
    end else begin
      if (w_rd) r_data <= r_ram[r_rptr];
      r_vld <= w_rd;
      r_sop <= w_rd && (r_rcnt == '0);
      r_eop <= w_rd && (r_rcnt == r_plen_m1);
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;
  assign o_sop  = r_sop;
  assign o_eop  = r_eop;

endmodule

// File: tb/tb_data_gen_wrap.sv
// Directed bench for data_gen_wrap: reset values, first-packet latency,
// packet content/framing through RAM wrap, and mid-packet async reset.
module tb_data_gen_wrap;

  logic        clk;
  logic        rst_n;
  logic        o_sop;
  logic        o_vld;
  logic [31:0] o_data;
  logic        o_eop;

  int tot = 0;
  int bad = 0;

  data_gen_wrap #(
    .GEN_INF_W   (32),
    .FIFO_ADDR_W (5),
    .RAM_ADDR_W  (5),
    .DW          (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_sop  (o_sop),
    .o_vld  (o_vld),
    .o_data (o_data),
    .o_eop  (o_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pkt_len(input int k);
`ifdef DGW_FIXED_LEN_EN
    return 8;
`else
    return (k % 32) + 1;
`endif
  endfunction

  // Wait (bounded) for packet k, then check up to nwords of it word by word.
  // A full packet is followed by a check of the mandatory idle cycle.
  task automatic check_pkt(input int k, input int bound, input int nwords);
    int n = 0;
    int len = pkt_len(k);
    int lim = (nwords < len) ? nwords : len;
    logic [31:0] e;
    while (o_vld !== 1'b1 && n < bound) begin
      chk($sformatf("idle_frame_p%0d", k), 32'({o_sop, o_eop}), 32'd0);
      @(negedge clk);
      n++;
    end
    chk($sformatf("vld_arrival_p%0d", k), 32'(o_vld), 32'd1);
    if (o_vld !== 1'b1) return;
    for (int i = 0; i < lim; i++) begin
      e = {16'(k), 16'(i)};
      chk($sformatf("vld_p%0d_w%0d", k, i), 32'(o_vld), 32'd1);
      chk($sformatf("sop_p%0d_w%0d", k, i), 32'(o_sop), 32'(i == 0));
      chk($sformatf("eop_p%0d_w%0d", k, i), 32'(o_eop), 32'(i == len - 1));
      chk($sformatf("data_p%0d_w%0d", k, i), o_data, e);
      if (i < lim - 1 || lim == len) @(negedge clk);
    end
    if (lim == len) chk($sformatf("gap_p%0d", k), 32'(o_vld), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    // Reset held two cycles: all outputs zero
    repeat (2) begin
      @(negedge clk);
      chk("rst_vld", 32'(o_vld), 32'd0);
      chk("rst_sop", 32'(o_sop), 32'd0);
      chk("rst_eop", 32'(o_eop), 32'd0);
      chk("rst_data", o_data, 32'd0);
    end
    rst_n = 1'b1;

    // Packet 0 within 6 cycles, then packets through RAM wrap (31 full, 32 L=1)
    check_pkt(0, 6, 64);
    for (int k = 1; k <= 40; k++) check_pkt(k, 200, 64);

    // Restart, run up to mid packet 31, then async reset without a clock edge
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_pkt(0, 6, 64);
    for (int k = 1; k <= 30; k++) check_pkt(k, 200, 64);
    check_pkt(31, 200, 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(o_vld), 32'd0);
    chk("midrst_sop", 32'(o_sop), 32'd0);
    chk("midrst_eop", 32'(o_eop), 32'd0);
    chk("midrst_data", o_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_pkt(0, 6, 64);
    check_pkt(1, 200, 64);
    check_pkt(2, 200, 64);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/data_gen_wrap.md
Name: data_gen_wrap

Overview:
- Self-contained packet traffic source used as a stimulus block for the multi-port cache data path.
- An internal generator builds packets of deterministic length and content. It writes payload into a ring-buffer RAM and pushes one info word per packet into an info FIFO.
- A send controller pops info words and streams each packet out with sop/vld/eop framing.
- No inputs besides clock and reset.

Parameters:
- GEN_INF_W, 32: info-word width; must be >= 32.
- FIFO_ADDR_W, 5: info FIFO address width; depth = 2^FIFO_ADDR_W.
- RAM_ADDR_W, 5: payload RAM address width; depth = 2^RAM_ADDR_W; max packet length = 2^RAM_ADDR_W words.
- DW, 32: output data width.

Ports:
- clk, input, 1: single clock; all logic rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- o_sop, output, 1: first word of packet; only asserted with o_vld.
- o_vld, output, 1: o_data valid this cycle.
- o_data, output, DW: payload word.
- o_eop, output, 1: last word of packet; only asserted with o_vld.

Behaviour:
- Reset: o_sop/o_vld/o_eop = 0, o_data = 0. FIFO and RAM pointers = 0, packet seq counter = 0, controller in IDLE. Reset mid-packet aborts the packet immediately; no eop is emitted.
- Packet k (seq = k mod 2^16):
  - Length L = (k mod 2^RAM_ADDR_W) + 1, so 1,2,...,32,1,2,... for defaults.
  - Word i (0..L-1) = {seq[15:0], i[15:0]}, truncated to the low DW bits or zero-extended to DW.
- Info word: [RAM_ADDR_W-1:0] = L-1; [31:16] = seq; other bits = 0.
- Generator:
  - Starts packet k only when the info FIFO is not full and RAM free space >= L.
  - Writes one payload word per cycle at the RAM write pointer; the pointer wraps modulo depth.
  - Pushes the info word in the same cycle as the last payload write, so the controller only sees complete packets.
  - Increments seq after the push.
  - Stalls, holding k, when the start condition is false.
- RAM free space = depth - occupied words. Occupied words increment on generator write and decrement on controller read; a simultaneous write and read leaves occupancy unchanged. The occupancy counter is RAM_ADDR_W+1 bits wide.
- Controller FSM, states IDLE, SEND:
  - IDLE: if FIFO not empty, pop the info word, latch L-1, go to SEND.
  - SEND: issue one RAM read per cycle at the read pointer. After L reads, return to IDLE.
  - Minimum one idle cycle between packets.
- RAM read is synchronous with 1-cycle latency. o_vld/o_sop/o_eop/o_data are registered and aligned with the RAM read data.
- o_vld is high for exactly L consecutive cycles per packet. o_sop is on the first of these cycles, o_eop on the last; for L = 1, sop and eop are in the same cycle.
- FIFO boundary conditions:
  - Full blocks the generator start.
  - Empty holds the controller in IDLE.
  - Simultaneous push and pop when full or empty is legal; count is unchanged.
- First o_vld occurs no later than 6 cycles after rst_n deasserts. Output is continuous traffic with no deadlock, since L <= RAM depth always.

Optional Feature:
- Macro: DGW_FIXED_LEN_EN.
- Defined: every packet length L = 8 (info bits [RAM_ADDR_W-1:0] = 7); seq and word content rules unchanged.
- Undefined: the incrementing length sequence above.

Decomposition:
- Shared package holds:
  - info-word field offsets (LEN_LSB = 0, SEQ_LSB = 16, SEQ_W = 16);
  - FSM state encoding (IDLE, SEND);
  - fixed length constant (8).
- One natural sub-module: dgw_sync_fifo, a parameterised synchronous FIFO (width GEN_INF_W, depth 2^FIFO_ADDR_W, full/empty flags). Instantiate it for the info FIFO.
- The payload RAM is an inferred array inside the top.

Test Plan:
- Reset held 2 cycles, then released -> outputs 0 during reset; first o_vld within 6 cycles with o_sop = o_eop = 1 and o_data = 0x0000_0000 (packet 0, L = 1).
- Run 1000 cycles -> packet 1 is 2 words: 0x0001_0000 with sop, then 0x0001_0001 with eop; packet 4 is 5 consecutive vld cycles, data 0x0004_0000..0x0004_0004.
- Packet 31 -> 32 consecutive vld words 0x001F_0000..0x001F_001F, sop on the first, eop on the last. Packet 32 -> L = 1, data 0x0020_0000; exercises RAM wrap and full RAM occupancy.
- Framing checker for the whole run -> never sop/eop without vld, never two sops without an eop between, at least 1 idle cycle between packets, seq strictly increasing by 1.
- Assert rst_n low mid-packet (e.g. during packet 31) -> outputs 0 on the next cycle, with no clock edge required. After release the stream restarts at packet 0 with data 0x0000_0000.
- With DGW_FIXED_LEN_EN defined -> every packet has exactly 8 vld cycles; packet 3 data 0x0003_0000..0x0003_0007.
